// File: rtl/serial_tx_pkg.sv
// Shared encodings and defaults for the serial pattern transmitter.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } tx_state_e;

  localparam int             DEF_DATA_W   = 8;
  localparam int             DEF_GAP_CYC  = 1;
  localparam int             DEF_PRE_W    = 4;
  localparam logic [3:0]     DEF_PREAMBLE = 4'b1011;

  // Counter width: enough for the longest reload value plus one spare bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Loadable down-counter with zero flag; times the PRE, SHIFT and GAP phases.
module tx_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-in, MSB-first serial transmitter with inter-word idle gap.
// Optional preamble before each word when SERIAL_TX_PREAMBLE_EN is defined.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int               DATA_W   = DEF_DATA_W,
  parameter int               GAP_CYC  = DEF_GAP_CYC,
  parameter int               PRE_W    = DEF_PRE_W,
  parameter logic [PRE_W-1:0] PREAMBLE = DEF_PREAMBLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ready,
  output logic              dout_bit,
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_width(DATA_W, PRE_W, GAP_CYC);
`ifdef SERIAL_TX_PREAMBLE_EN
  localparam int FW = PRE_W + DATA_W;
  localparam logic [CW-1:0] PRE_LD = CW'(PRE_W - 1);
`else
  localparam int FW = DATA_W;
`endif
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

  tx_state_e     state_q, state_d;
  logic [FW-1:0] fr_q, fr_d, frame_w;
  logic          bit_q, bit_d, vld_q, vld_d, done_q, done_d;
  logic          cnt_ld, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val, cnt_q;

  // Preamble and word share one shift register so PRE and SHIFT shift identically.
`ifdef SERIAL_TX_PREAMBLE_EN
  assign frame_w = {PREAMBLE, din_data};
`else
  assign frame_w = din_data;
`endif

  tx_bit_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_ld),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .cnt_o  (cnt_q),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    fr_d    = fr_q;
    bit_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    cnt_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          bit_d  = frame_w[FW-1];
          vld_d  = 1'b1;
          fr_d   = {frame_w[FW-2:0], 1'b0};
          cnt_ld = 1'b1;
`ifdef SERIAL_TX_PREAMBLE_EN
          state_d = S_PRE;
          cnt_val = PRE_LD;
`else
          state_d = S_SHIFT;
          cnt_val = DATA_LD;
`endif
        end
      end
`ifdef SERIAL_TX_PREAMBLE_EN
      S_PRE: begin
        bit_d = fr_q[FW-1];
        vld_d = 1'b1;
        fr_d  = {fr_q[FW-2:0], 1'b0};
        if (cnt_zero) begin
          state_d = S_SHIFT;
          cnt_ld  = 1'b1;
          cnt_val = DATA_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`endif
      S_SHIFT: begin
        if (!cnt_zero) begin
          bit_d   = fr_q[FW-1];
          vld_d   = 1'b1;
          fr_d    = {fr_q[FW-2:0], 1'b0};
          cnt_dec = 1'b1;
        end else begin
          // Last bit is on the wire now; done shows in the following cycle.
          done_d = 1'b1;
          if (GAP_CYC > 0) begin
            state_d = S_GAP;
            cnt_ld  = 1'b1;
            cnt_val = GAP_LD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_dec = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fr_q    <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fr_q    <= fr_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign din_ready  = (state_q == S_IDLE);
  assign busy       = ~din_ready;
  assign dout_bit   = bit_q;
  assign dout_valid = vld_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomized self-checking bench for serial_pattern_tx against a frame-level model.
module tb_serial_pattern_tx;

  localparam int         DATA_W   = 8;
  localparam int         GAP_CYC  = 1;
  localparam int         PRE_W    = 4;
  localparam logic [3:0] PREAMBLE = 4'b1011;
`ifdef SERIAL_TX_PREAMBLE_EN
  localparam int FW = PRE_W + DATA_W;
`else
  localparam int FW = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              din_valid = 1'b0;
  logic [DATA_W-1:0] din_data = '0;
  logic              din_ready, dout_bit, dout_valid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_pattern_tx #(
    .DATA_W(DATA_W), .GAP_CYC(GAP_CYC), .PRE_W(PRE_W), .PREAMBLE(PREAMBLE)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_data(din_data),
    .din_ready(din_ready), .dout_bit(dout_bit), .dout_valid(dout_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: the frame is the preamble (if enabled) followed by the word, sent MSB-first.
  function automatic logic [FW-1:0] model_frame(input logic [DATA_W-1:0] w);
`ifdef SERIAL_TX_PREAMBLE_EN
    return {PREAMBLE, w};
`else
    return w;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if (dout_valid !== 1'b0 || dout_bit !== 1'b0 || done !== 1'b0 ||
        din_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: valid=%b bit=%b done=%b ready=%b busy=%b, want 0 0 0 1 0",
               tag, dout_valid, dout_bit, done, din_ready, busy);
    end
  endtask

  // Called at a negedge. Offers w, then checks every cycle until ready returns.
  // After the accept, din is driven with (hold ? nxt : random) to prove capture.
  task automatic send_check(input logic [DATA_W-1:0] w, input logic hold,
                            input logic [DATA_W-1:0] nxt, input string tag);
    logic [FW-1:0] f;
    int waited;
    f = model_frame(w);
    waited = 0;
    while (din_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_timeout: ready=%b want 1", tag, din_ready);
      return;
    end
    din_valid = 1'b1;
    din_data  = w;
    for (int k = 0; k < FW; k++) begin
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b1 || dout_bit !== f[FW-1-k] || done !== 1'b0 ||
          din_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_bit%0d: valid=%b bit=%b done=%b ready=%b busy=%b, want 1 %b 0 0 1",
                 tag, k, dout_valid, dout_bit, done, din_ready, busy, f[FW-1-k]);
      end
      if (k == 0) begin
        din_valid = hold;
        din_data  = hold ? nxt : DATA_W'($urandom);
      end else if (!hold) begin
        din_valid = 1'($urandom);
        din_data  = DATA_W'($urandom);
      end
    end
    if (!hold) din_valid = 1'b0;
    for (int g = 0; g <= GAP_CYC; g++) begin
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b0 || dout_bit !== 1'b0 || done !== (g == 0) ||
          din_ready !== (g == GAP_CYC)) begin
        n_fail++;
        $display("FAIL %s_tail%0d: valid=%b bit=%b done=%b ready=%b, want 0 0 %b %b",
                 tag, g, dout_valid, dout_bit, done, din_ready, g == 0, g == GAP_CYC);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din_valid = 1'b1;
    din_data  = 8'hB3;
    #15;
    check_idle_outputs("reset_hold");
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_edges");
    rst = 1'b1;
    send_check(8'hB3, 1'b0, '0, "reset_release");
  endtask

  task automatic test_single();
    @(negedge clk);
    send_check(8'hB3, 1'b0, '0, "single_b3");
  endtask

  task automatic test_back_to_back();
    send_check(8'hFF, 1'b1, 8'h00, "b2b_ff");
    send_check(8'h00, 1'b0, '0, "b2b_00");
  endtask

  task automatic test_pattern_2c();
    send_check(8'b0010_1100, 1'b0, '0, "pat_2c");
  endtask

  task automatic test_no_sticky();
    send_check(8'h81, 1'b0, '0, "nosticky_word");
    repeat (4) begin
      @(negedge clk);
      check_idle_outputs("nosticky_idle");
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    din_valid = 1'b1;
    din_data  = 8'hAA;
    repeat (3) @(negedge clk);
    din_valid = 1'b0;
    n_checks++;
    if (dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_live: valid=%b want 1", dout_valid);
    end
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("midrst_async");
    @(negedge clk);
    check_idle_outputs("midrst_held");
    rst = 1'b1;
    send_check(8'h5A, 1'b0, '0, "midrst_5a");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [DATA_W-1:0] w;
      w = DATA_W'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_idle_outputs("rand_idle");
      end
      send_check(w, 1'b0, '0, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_pattern_2c();
    test_no_sticky();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, want finish");
    $fatal(1);
  end

endmodule
